uart_tx_datapath: RTL and testbench

- Serial datapath of the UART transmitter: 8-bit parallel-in/serial-out shift register (LSB first), combinational parity generator, and a 4:1 frame-slot mux.
- Produces the TX line bit for the current frame slot (start, data, parity, stop).
- An external transmit FSM drives `load`, `parity_enable` and `select`.
- Sits between the APB-facing UART registers/FSM and the TX pin, clocked at the baud tick clock.

---
 rtl/uart_tx_pkg.sv | 11 +
 rtl/uart_tx_if.sv | 26 ++
 rtl/uart_parity_gen.sv | 13 +
 rtl/uart_piso.sv | 40 ++++
 rtl/uart_tx_mux.sv | 22 ++
 rtl/uart_tx_datapath.sv | 46 ++++
 tb/tb_uart_tx_datapath.sv | 214 +++++++++++++++++++++
 7 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit datapath: frame-slot encodings.
package uart_tx_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_START  = 2'b00;
  localparam sel_t SEL_DATA   = 2'b01;
  localparam sel_t SEL_PARITY = 2'b10;
  localparam sel_t SEL_STOP   = 2'b11;

endpackage

// File: rtl/uart_tx_if.sv
// Control/status bundle between the transmit FSM (master) and the TX datapath (slave).
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  import uart_tx_pkg::*;

  logic                  load;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  parity_enable;
  sel_t                  select;
  logic                  tx_out;
  logic                  data_bit;
  logic                  parity_bit;
  logic                  data_sent;

  modport master (
    output load, data_in, parity_enable, select,
    input  tx_out, data_bit, parity_bit, data_sent
  );

  modport slave (
    input  load, data_in, parity_enable, select,
    output tx_out, data_bit, parity_bit, data_sent
  );

endinterface

// File: rtl/uart_parity_gen.sv
// Combinational parity over the parallel word; the word must stay stable through the parity slot.
module uart_parity_gen #(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  parity_enable,
  output logic                  parity_bit
);

  assign parity_bit = parity_enable & (^data_in ^ PARITY_ODD);

endmodule

// File: rtl/uart_piso.sv
// LSB-first parallel-in/serial-out shift register with a saturating bit counter.
module uart_piso #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_bit,
  output logic                  data_sent
);

  localparam int              CW      = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;

  // Shifting stops once every bit has gone out, so the line idles on the 1-fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      cnt       <= '0;
      data_sent <= 1'b0;
    end else if (load) begin
      shreg     <= data_in;
      cnt       <= '0;
      data_sent <= 1'b0;
    end else if (cnt < CNT_MAX) begin
      shreg <= {1'b1, shreg[DATA_WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
      if (cnt == CNT_MAX - 1'b1) begin
        data_sent <= 1'b1;
      end
    end
  end

  assign data_bit = shreg[0];

endmodule

// File: rtl/uart_tx_mux.sv
// Frame-slot selector driving the TX line; anything unrecognised idles high.
module uart_tx_mux
  import uart_tx_pkg::*;
(
  input  sel_t select,
  input  logic data_bit,
  input  logic parity_bit,
  output logic tx_out
);

  always_comb begin
    tx_out = 1'b1;
    case (select)
      SEL_START:  tx_out = 1'b0;
      SEL_DATA:   tx_out = data_bit;
      SEL_PARITY: tx_out = parity_bit;
      SEL_STOP:   tx_out = 1'b1;
      default:    tx_out = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_tx_datapath.sv
// UART transmit datapath: shift register, parity generator and frame-slot mux.
module uart_tx_datapath
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,   // active-high despite the name
  uart_tx_if.slave bus
);

  logic data_bit;
  logic parity_bit;

  uart_piso #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_piso (
    .clk       (clk),
    .rst       (rst_n),
    .load      (bus.load),
    .data_in   (bus.data_in),
    .data_bit  (data_bit),
    .data_sent (bus.data_sent)
  );

  uart_parity_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARITY_ODD (PARITY_ODD)
  ) u_parity_gen (
    .data_in       (bus.data_in),
    .parity_enable (bus.parity_enable),
    .parity_bit    (parity_bit)
  );

  uart_tx_mux u_tx_mux (
    .select     (bus.select),
    .data_bit   (data_bit),
    .parity_bit (parity_bit),
    .tx_out     (bus.tx_out)
  );

  assign bus.data_bit   = data_bit;
  assign bus.parity_bit = parity_bit;

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Directed bench for uart_tx_datapath: expectations queued per step, then popped and asserted.
module tb_uart_tx_datapath;
  import uart_tx_pkg::*;

  typedef enum int {SIG_TX, SIG_DBIT, SIG_PAR, SIG_SENT, SIG_PAR_ODD} sig_e;
  typedef struct {
    string tag;
    sig_e  sig;
    logic  exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();
  uart_tx_if #(.DATA_WIDTH(8)) bus_odd ();

  uart_tx_datapath #(.DATA_WIDTH(8), .PARITY_ODD(1'b0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  uart_tx_datapath #(.DATA_WIDTH(8), .PARITY_ODD(1'b1)) u_dut_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_odd)
  );

  exp_t sb[$];
  int   total = 0;
  int   fails = 0;

  function automatic logic observe(sig_e s);
    case (s)
      SIG_TX:      return bus.tx_out;
      SIG_DBIT:    return bus.data_bit;
      SIG_PAR:     return bus.parity_bit;
      SIG_SENT:    return bus.data_sent;
      SIG_PAR_ODD: return bus_odd.parity_bit;
      default:     return 1'bx;
    endcase
  endfunction

  task automatic expect_bit(input string tag, input sig_e s, input logic e);
    exp_t x;
    x.tag = tag;
    x.sig = s;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_all();
    exp_t x;
    logic obs;
    while (sb.size() > 0) begin
      x   = sb.pop_front();
      obs = observe(x.sig);
      total++;
      assert (obs === x.exp) else begin
        fails++;
        $error("FAIL %s: observed %b expected %b", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start slot overlaps the load cycle, then 8 data slots, parity, stop.
  task automatic run_frame(input string name, input logic [7:0] w, input logic par_exp);
    bus.parity_enable = 1'b1;
    bus.data_in       = w;
    bus.load          = 1'b1;
    bus.select        = SEL_START;
    #1;
    expect_bit({name, "_start"}, SIG_TX, 1'b0);
    check_all();
    tick();
    expect_bit({name, "_sent_cleared"}, SIG_SENT, 1'b0);
    check_all();
    bus.load   = 1'b0;
    bus.select = SEL_DATA;
    for (int k = 0; k < 8; k++) begin
      #1;
      expect_bit($sformatf("%s_d%0d", name, k), SIG_TX, w[k]);
      check_all();
      tick();
    end
    bus.select = SEL_PARITY;
    #1;
    expect_bit({name, "_parity"}, SIG_TX, par_exp);
    expect_bit({name, "_sent"}, SIG_SENT, 1'b1);
    check_all();
    bus.select = SEL_STOP;
    #1;
    expect_bit({name, "_stop"}, SIG_TX, 1'b1);
    check_all();
    tick();
  endtask

  logic [7:0] w;

  initial begin
    rst_n                 = 1'b1;
    bus.load              = 1'b0;
    bus.data_in           = 8'h00;
    bus.parity_enable     = 1'b0;
    bus.select            = SEL_STOP;
    bus_odd.load          = 1'b0;
    bus_odd.data_in       = 8'h00;
    bus_odd.parity_enable = 1'b1;
    bus_odd.select        = SEL_STOP;

    #12;
    expect_bit("rst_data_bit", SIG_DBIT, 1'b0);
    expect_bit("rst_data_sent", SIG_SENT, 1'b0);
    expect_bit("rst_tx_idle", SIG_TX, 1'b1);
    check_all();
    rst_n = 1'b0;

    // Load and shift out 8'b10101010
    w           = 8'hAA;
    bus.data_in = w;
    bus.load    = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      expect_bit($sformatf("shift_d%0d", k), SIG_DBIT, w[k]);
      expect_bit($sformatf("shift_sent_low%0d", k), SIG_SENT, 1'b0);
      check_all();
      tick();
    end
    expect_bit("shift_sent_high", SIG_SENT, 1'b1);
    check_all();
    tick();
    tick();
    expect_bit("shift_sent_hold", SIG_SENT, 1'b1);
    expect_bit("shift_fill_hold", SIG_DBIT, 1'b1);
    check_all();

    // Even parity vectors
    bus.parity_enable = 1'b1;
    bus.data_in       = 8'b11101010;
    #1;
    expect_bit("par_even_ea", SIG_PAR, 1'b1);
    check_all();
    bus.data_in = 8'b10101010;
    #1;
    expect_bit("par_even_aa", SIG_PAR, 1'b0);
    check_all();
    bus.data_in       = 8'b11101010;
    bus.parity_enable = 1'b0;
    #1;
    expect_bit("par_disabled", SIG_PAR, 1'b0);
    check_all();
    tick();

    run_frame("frame1", 8'b10101011, 1'b1);
    expect_bit("frame2_sent_before_load", SIG_SENT, 1'b1);
    check_all();
    run_frame("frame2", 8'b11100101, 1'b1);

    // Reload after three shifts restarts the word and the counter
    bus.data_in = 8'hFF;
    bus.load    = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    tick();
    w           = 8'b00011001;
    bus.data_in = w;
    bus.load    = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      expect_bit($sformatf("reload_d%0d", k), SIG_DBIT, w[k]);
      expect_bit($sformatf("reload_sent_low%0d", k), SIG_SENT, 1'b0);
      check_all();
      tick();
    end
    expect_bit("reload_sent_high", SIG_SENT, 1'b1);
    expect_bit("reload_fill", SIG_DBIT, 1'b1);
    check_all();

    // Asynchronous reset between edges, with load held high
    bus.load    = 1'b1;
    bus.data_in = 8'hFF;
    bus.select  = SEL_STOP;
    #2;
    rst_n = 1'b1;
    #1;
    expect_bit("async_rst_data_bit", SIG_DBIT, 1'b0);
    expect_bit("async_rst_data_sent", SIG_SENT, 1'b0);
    expect_bit("async_rst_tx_stop", SIG_TX, 1'b1);
    check_all();
    tick();
    expect_bit("rst_overrides_load", SIG_DBIT, 1'b0);
    expect_bit("odd_parity_zero_word", SIG_PAR_ODD, 1'b1);
    check_all();

    rst_n    = 1'b0;
    bus.load = 1'b0;
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
